// File: rtl/hazarddetect.sv
// rtl/hazarddetect.sv - semiMIPS hazard detection: load-use stall, memwait freeze, branch flush.
// Optional statistics counters (stallcnt/flushcnt) are built when HAZARD_STATS_EN is defined.
module hazarddetect #(
    parameter int REGW = 5
`ifdef HAZARD_STATS_EN
    , parameter int CNTW = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] idrs,
    input  logic [REGW-1:0] idrt,
    input  logic            idusert,
    input  logic            exmemrd,
    input  logic [REGW-1:0] exrt,
    input  logic            memwait,
    input  logic            brtaken,
    output logic            ctrlsig,
    output logic            pcwrite,
    output logic            ifidwrite,
    output logic            ifidflush,
    output logic            exmemflush,
    output logic            exmemwrite
`ifdef HAZARD_STATS_EN
    , output logic [CNTW-1:0] stallcnt
    , output logic [CNTW-1:0] flushcnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT      = 2'd1,
        FLUSHPEND = 2'd2
    } state_t;

    state_t state;
    logic   pending;
    logic   loaduse;
    logic   flush;
    logic   stall;

    always_comb begin
        loaduse = exmemrd && (exrt != '0) &&
                  ((exrt == idrs) || (idusert && (exrt == idrt)));
        // A branch seen while still in WAIT is only remembered; it flushes from FLUSHPEND.
        flush   = !memwait && ((state == FLUSHPEND) || ((state == RUN) && brtaken));
        stall   = !memwait && !flush && loaduse;
    end

    always_comb begin
        ctrlsig    = 1'b0;
        pcwrite    = 1'b1;
        ifidwrite  = 1'b1;
        ifidflush  = 1'b0;
        exmemflush = 1'b0;
        exmemwrite = 1'b1;
        if (rst) begin
            ctrlsig    = 1'b1;
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            ifidflush  = 1'b1;
            exmemflush = 1'b1;
            exmemwrite = 1'b0;
        end else if (memwait) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            exmemwrite = 1'b0;
        end else if (flush) begin
            ctrlsig    = 1'b1;
            ifidflush  = 1'b1;
            exmemflush = 1'b1;
        end else if (stall) begin
            ctrlsig    = 1'b1;
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pending <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (memwait) begin
                        pending <= pending | brtaken;
                    end else begin
                        state   <= (pending || brtaken) ? FLUSHPEND : RUN;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= memwait ? WAIT : RUN;
                    pending <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallcnt <= '0;
            flushcnt <= '0;
        end else begin
            if ((memwait || stall) && (stallcnt != '1)) begin
                stallcnt <= stallcnt + 1'b1;
            end
            if (flush && (flushcnt != '1)) begin
                flushcnt <= flushcnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/hazarddetect.md
# hazarddetect

Pipeline hazard detection unit for the semiMIPS 5-stage core; the driver of the `ctrlsig` select on the control-signal NOP mux that sits between the control unit and the ID/EX register. It detects load-use hazards, freezes the pipeline while data memory is busy, and flushes wrong-path instructions after a taken branch or jump resolved in MEM. Its outputs feed the ID/EX NOP mux, the PC write enable, the IF/ID register, and the EX/MEM register.

## Interface
Parameters:
- `REGW`, 5, register-specifier width.
- `CNTW`, 16, width of the statistics counters; present only with `HAZARD_STATS_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `idrs`  in  REGW  rs field of the instruction in ID.
- `idrt`  in  REGW  rt field of the instruction in ID.
- `idusert`  in  1  ID instruction reads rt as a source.
- `exmemrd`  in  1  `memrd` from the ID/EX register, i.e. a load is in EX.
- `exrt`  in  REGW  destination rt of the load in EX.
- `memwait`  in  1  data memory not ready; the pipeline must hold.
- `brtaken`  in  1  taken branch or jump resolved in MEM.
- `ctrlsig`  out  1  NOP-mux select: 0 passes control-unit signals, 1 inserts a bubble.
- `pcwrite`  out  1  PC update enable.
- `ifidwrite`  out  1  IF/ID load enable.
- `ifidflush`  out  1  IF/ID clear to NOP.
- `exmemflush`  out  1  EX/MEM control-field clear.
- `exmemwrite`  out  1  EX/MEM and MEM/WB load enable.
- `stallcnt`  out  CNTW  load-use plus memwait stall cycles; `HAZARD_STATS_EN` only.
- `flushcnt`  out  CNTW  flush events; `HAZARD_STATS_EN` only.

## Operation
- FSM states: RUN, WAIT, FLUSHPEND. Reset state is RUN.
- Priority in every cycle: `rst` > `memwait` > flush > load-use.
- Load-use hazard:
  - Definition: `exmemrd && exrt!=0 && (exrt==idrs || (idusert && exrt==idrt))`.
  - Response in RUN: `ctrlsig=1`, `pcwrite=0`, `ifidwrite=0`. All other outputs keep their normal values.
  - Register 0 never causes a hazard.
- Memwait:
  - From RUN or FLUSHPEND, `memwait=1` drives all enables (`pcwrite`, `ifidwrite`, `exmemwrite`) to 0, all flushes to 0, and `ctrlsig` to 0. The state becomes WAIT.
  - If `brtaken=1` in a WAIT cycle, pending is set to 1. Pending is cleared on leaving WAIT.
  - On the cycle `memwait` falls, the state becomes FLUSHPEND if pending or `brtaken` is 1; otherwise it becomes RUN.
- Flush:
  - Triggered by FLUSHPEND, or by RUN with `brtaken=1` and `memwait=0`.
  - Response: `ifidflush=1`, `ctrlsig=1`, `exmemflush=1`, `pcwrite=1` (target loads), `ifidwrite=1`, `exmemwrite=1`.
  - A flush overrides a simultaneous load-use stall; the stalled instruction is on the wrong path.
  - FLUSHPEND returns to RUN after one cycle.
- Normal (RUN, no event): `ctrlsig=0`, `pcwrite=ifidwrite=exmemwrite=1`, flushes 0.
- Reset outputs, held while `rst=1`:
  - `ctrlsig=1`, `pcwrite=0`, `ifidwrite=0`, `exmemwrite=0`, `ifidflush=1`, `exmemflush=1`.
  - The FSM is RUN, pending is 0, and the counters are 0.
- Reset mid-WAIT or mid-FLUSHPEND abandons the pending flush.

## Timing
- All outputs are combinational from the current inputs plus the state register, with zero-cycle latency. The effect lands at the next rising edge.
- A load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM, `exmemrd` is a bubble, and the hazard clears naturally.
- A flush lasts exactly 1 cycle. A flush deferred by memwait issues on the first cycle after `memwait` deasserts.
- State and counter updates happen at the rising edge. A synchronous reset takes effect at the edge where `rst=1` is sampled.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stallcnt` increments by 1 on each load-use stall cycle and each memwait cycle.
  - `flushcnt` increments by 1 on each flush cycle.
  - Both counters saturate at all-ones and are cleared by `rst`.
- `HAZARD_STATS_EN` undefined: both counter ports and their registers are absent. Control behaviour is identical in both builds.

## Test plan
- Load-use hazard: `exmemrd=1`, `exrt=8`, `idrs=8`, one cycle → `ctrlsig=1`, `pcwrite=0`, `ifidwrite=0` for 1 cycle. Next cycle with `exmemrd=0` → normal outputs; `stallcnt=1`.
- Register 0 and rt gating:
  - `exrt=0`, `idrs=0`, `exmemrd=1` → no stall.
  - `exrt=9`, `idrt=9`, `idusert=0` → no stall.
  - Same with `idusert=1` → stall.
- Deferred flush: `memwait=1` for 3 cycles with a `brtaken=1` pulse in cycle 2 → all enables 0 for 3 cycles and no flush. On the cycle after `memwait` falls, `ifidflush=exmemflush=ctrlsig=1` for exactly 1 cycle; `flushcnt=1`, `stallcnt=3`.
- Flush beats load-use: `brtaken=1` together with a load-use match in RUN → flush outputs asserted with `pcwrite=1`, no stall; `stallcnt` unchanged.
- Reset during WAIT with pending set: `rst=1` for 1 cycle, then `memwait=0`, `brtaken=0` → no flush issued. Outputs return to normal and counters read 0.
- Counter saturation (`HAZARD_STATS_EN`, `CNTW=4`): 20 consecutive memwait cycles → `stallcnt=15`.
